// File: rtl/global_buffer_param.sv
// Tile-level sizing constants shared by the global buffer write path.
package global_buffer_param;
  localparam int BANKS_PER_TILE        = 2;
  localparam int BANK_ADDR_WIDTH       = 17;
  localparam int BANK_DATA_WIDTH       = 64;
  localparam int GLB_ADDR_WIDTH        = 32;
  localparam int GLB_WR_MUX_FIFO_DEPTH = 4;
endpackage

// File: rtl/global_buffer_pkg.sv
// Write packet type and bank-select helper for the global buffer write path.
package global_buffer_pkg;
  import global_buffer_param::*;

  localparam int BANK_SEL_LSB   = BANK_ADDR_WIDTH;
  localparam int BANK_SEL_WIDTH = (BANKS_PER_TILE > 1) ? $clog2(BANKS_PER_TILE) : 1;

  typedef struct packed {
    logic                         wr_en;
    logic [BANK_DATA_WIDTH/8-1:0] wr_strb;
    logic [BANK_DATA_WIDTH-1:0]   wr_data;
    logic [GLB_ADDR_WIDTH-1:0]    wr_addr;
  } wr_packet_t;

  function automatic logic [BANK_SEL_WIDTH-1:0] bank_sel(input logic [GLB_ADDR_WIDTH-1:0] addr);
    return addr[BANK_SEL_LSB +: BANK_SEL_WIDTH];
  endfunction
endpackage

// File: rtl/glb_wr_fifo.sv
// Ordered buffer for store-DMA write packets; head is visible combinationally.
// Pointers carry a wrap bit so full and empty are distinguished without a counter.
module glb_wr_fifo
  import global_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       push,
  input  wr_packet_t push_packet,
  input  logic       pop,
  output wr_packet_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wr_packet_t  mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clk_en) begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // A push into a full FIFO only happens alongside a pop, so it reuses the slot being read out.
  always_ff @(posedge clk) begin
    if (clk_en && push) mem[wr_ptr[AW-1:0]] <= push_packet;
  end
endmodule

// File: rtl/glb_core_bank_wr_mux.sv
// Merges processor writes (fixed priority) with the store-DMA stream and steers the winner to its bank register.
// Optional GLB_WR_MUX_STATS_EN adds saturating issued/stalled stream counters.
module glb_core_bank_wr_mux
  import global_buffer_param::*;
  import global_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH = GLB_WR_MUX_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  wr_packet_t strm_wr_packet,
  input  wr_packet_t proc_wr_packet,
  input  logic       cfg_wr_mux_clr,
  output wr_packet_t bank_wr_packet [BANKS_PER_TILE],
  output logic       strm_wr_pending,
`ifdef GLB_WR_MUX_STATS_EN
  output logic [31:0] strm_wr_count,
  output logic [15:0] strm_stall_count,
`endif
  output logic       strm_overflow
);
  wr_packet_t                fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      push_req;
  logic                      drop;
  wr_packet_t                winner;
  logic                      win_strm;
  logic [BANK_SEL_WIDTH-1:0] sel;
  logic                      strm_out;

  glb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .push        (push),
    .push_packet (strm_wr_packet),
    .pop         (pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Stream may bypass the FIFO only when nothing older is waiting in it.
  always_comb begin
    winner   = '0;
    win_strm = 1'b0;
    pop      = 1'b0;
    push_req = 1'b0;
    if (proc_wr_packet.wr_en) begin
      winner   = proc_wr_packet;
      push_req = strm_wr_packet.wr_en;
    end else if (!fifo_empty) begin
      winner   = fifo_head;
      win_strm = 1'b1;
      pop      = 1'b1;
      push_req = strm_wr_packet.wr_en;
    end else if (strm_wr_packet.wr_en) begin
      winner   = strm_wr_packet;
      win_strm = 1'b1;
    end
  end

  assign push            = push_req && (!fifo_full || pop);
  assign drop            = push_req && fifo_full && !pop;
  assign sel             = bank_sel(winner.wr_addr);
  assign strm_wr_pending = !fifo_empty || strm_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < BANKS_PER_TILE; b++) bank_wr_packet[b] <= '0;
      strm_out      <= 1'b0;
      strm_overflow <= 1'b0;
    end else if (clk_en) begin
      for (int b = 0; b < BANKS_PER_TILE; b++)
        bank_wr_packet[b] <= (winner.wr_en && (int'(sel) == b)) ? winner : '0;
      strm_out <= win_strm;
      if (drop)                strm_overflow <= 1'b1;
      else if (cfg_wr_mux_clr) strm_overflow <= 1'b0;
    end
  end

`ifdef GLB_WR_MUX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strm_wr_count    <= '0;
      strm_stall_count <= '0;
    end else if (clk_en) begin
      if (cfg_wr_mux_clr) begin
        strm_wr_count    <= '0;
        strm_stall_count <= '0;
      end else begin
        if (win_strm && (strm_wr_count != '1)) strm_wr_count <= strm_wr_count + 32'd1;
        if (push && (strm_stall_count != '1))  strm_stall_count <= strm_stall_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_glb_core_bank_wr_mux.sv
// Directed stimulus with a scoreboard queue of expected bank writes (packet, bank, cycle).
module tb_glb_core_bank_wr_mux;
  import global_buffer_param::*;
  import global_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  wr_packet_t strm_wr_packet;
  wr_packet_t proc_wr_packet;
  logic       cfg_wr_mux_clr;
  wr_packet_t bank_wr_packet [BANKS_PER_TILE];
  logic       strm_wr_pending;
  logic       strm_overflow;
`ifdef GLB_WR_MUX_STATS_EN
  logic [31:0] strm_wr_count;
  logic [15:0] strm_stall_count;
`endif

  glb_core_bank_wr_mux dut (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (clk_en),
    .strm_wr_packet  (strm_wr_packet),
    .proc_wr_packet  (proc_wr_packet),
    .cfg_wr_mux_clr  (cfg_wr_mux_clr),
    .bank_wr_packet  (bank_wr_packet),
    .strm_wr_pending (strm_wr_pending),
`ifdef GLB_WR_MUX_STATS_EN
    .strm_wr_count   (strm_wr_count),
    .strm_stall_count(strm_stall_count),
`endif
    .strm_overflow   (strm_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    wr_packet_t pkt;
    int         bank;
    int         cyc;
  } exp_t;

  exp_t       sb [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic       en_q;
  wr_packet_t idle_pkt = '0;
  int         base;
  int         m_hits;
  int         m_bank;
  exp_t       m_e;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge reset) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= clk_en;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic wr_packet_t mk(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    wr_packet_t p;
    p         = '0;
    p.wr_en   = 1'b1;
    p.wr_strb = strb;
    p.wr_data = data;
    p.wr_addr = addr;
    return p;
  endfunction

  // Address bit 17 selects the bank in this configuration.
  task automatic expect_at(input wr_packet_t p, input int at);
    exp_t e;
    e.pkt  = p;
    e.bank = int'(p.wr_addr[17]);
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic step(input wr_packet_t p, input wr_packet_t s, input logic clr, input logic en);
    @(posedge clk);
    #1;
    proc_wr_packet = p;
    strm_wr_packet = s;
    cfg_wr_mux_clr = clr;
    clk_en         = en;
  endtask

  // Monitor: every enabled cycle, at most one bank may write and it must match the queue head.
  always @(negedge clk) begin
    if (!reset && en_q) begin
      m_hits = 0;
      m_bank = 0;
      for (int b = 0; b < BANKS_PER_TILE; b++) begin
        if (bank_wr_packet[b].wr_en) begin
          m_hits++;
          m_bank = b;
        end else if (bank_wr_packet[b] != '0) begin
          chk("idle_bank_zero", 128'(bank_wr_packet[b]), 128'(0));
        end
      end
      if (m_hits > 1) begin
        chk("one_bank_only", 128'(m_hits), 128'(1));
      end else if (m_hits == 1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 128'(bank_wr_packet[m_bank]), 128'(0));
        end else begin
          m_e = sb.pop_front();
          chk("mon_packet", 128'(bank_wr_packet[m_bank]), 128'(m_e.pkt));
          chk("mon_bank", 128'(m_bank), 128'(m_e.bank));
          chk("mon_cycle", 128'(cyc), 128'(m_e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        m_e = sb.pop_front();
        chk("missing_write", 128'(0), 128'(m_e.pkt));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    clk_en         = 1'b1;
    proc_wr_packet = '0;
    strm_wr_packet = '0;
    cfg_wr_mux_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < BANKS_PER_TILE; b++) chk("reset_bank", 128'(bank_wr_packet[b]), 128'(0));
    chk("reset_pending", 128'(strm_wr_pending), 128'(0));
    chk("reset_overflow", 128'(strm_overflow), 128'(0));
`ifdef GLB_WR_MUX_STATS_EN
    chk("reset_wr_count", 128'(strm_wr_count), 128'(0));
    chk("reset_stall_count", 128'(strm_stall_count), 128'(0));
`endif
    reset = 1'b0;

    // Stream bypass to bank 0; pending high only in the output cycle.
    step(idle_pkt, mk(32'h0000_0000, 64'h1111_2222_3333_4444, 8'hFF), 1'b0, 1'b1);
    expect_at(mk(32'h0000_0000, 64'h1111_2222_3333_4444, 8'hFF), cyc + 1);
    @(negedge clk);
    chk("pending_before", 128'(strm_wr_pending), 128'(0));
    step(idle_pkt, idle_pkt, 1'b0, 1'b1);
    @(negedge clk);
    chk("pending_during", 128'(strm_wr_pending), 128'(1));
    step(idle_pkt, idle_pkt, 1'b0, 1'b1);
    @(negedge clk);
    chk("pending_after", 128'(strm_wr_pending), 128'(0));

    // Stream bypass to bank 1, address unchanged.
    step(idle_pkt, mk(32'h0002_0040, 64'h0000_0000_0000_00B1, 8'h0F), 1'b0, 1'b1);
    expect_at(mk(32'h0002_0040, 64'h0000_0000_0000_00B1, 8'h0F), cyc + 1);

    // Clock enable low: output holds and the stream input is not sampled.
    step(mk(32'h0002_0100, 64'h0000_0000_0000_0E0E, 8'h55), idle_pkt, 1'b0, 1'b1);
    expect_at(mk(32'h0002_0100, 64'h0000_0000_0000_0E0E, 8'h55), cyc + 1);
    step(idle_pkt, mk(32'h0000_0080, 64'h0000_0000_0000_DEAD, 8'h03), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("hold_bank1", 128'(bank_wr_packet[1]), 128'(mk(32'h0002_0100, 64'h0000_0000_0000_0E0E, 8'h55)));
    strm_wr_packet = '0;
    clk_en         = 1'b1;
    repeat (2) step(idle_pkt, idle_pkt, 1'b0, 1'b1);

    // Proc x3 with stream A,B,C: proc first, then A,B,C in order.
    for (int i = 0; i < 3; i++) begin
      step(mk(32'h0000_1000 + 32'(i * 8), 64'h0000_0000_0000_A000 + 64'(i), 8'hFF),
           mk(32'h0002_2000 + 32'(i * 8), 64'h0000_0000_0000_C000 + 64'(i), 8'hF0), 1'b0, 1'b1);
      if (i == 0) base = cyc;
      expect_at(mk(32'h0000_1000 + 32'(i * 8), 64'h0000_0000_0000_A000 + 64'(i), 8'hFF), cyc + 1);
    end
    for (int i = 0; i < 3; i++)
      expect_at(mk(32'h0002_2000 + 32'(i * 8), 64'h0000_0000_0000_C000 + 64'(i), 8'hF0), base + 4 + i);
    @(negedge clk);
    chk("pending_queued", 128'(strm_wr_pending), 128'(1));
    repeat (5) step(idle_pkt, idle_pkt, 1'b0, 1'b1);
    chk("no_overflow", 128'(strm_overflow), 128'(0));

    // Proc busy 6 cycles, stream every cycle: 4 queued, 2 dropped.
    for (int i = 0; i < 6; i++) begin
      step(mk(32'h0002_3000 + 32'(i * 8), 64'h0000_0000_0000_D000 + 64'(i), 8'h0F),
           mk(32'h0000_4000 + 32'(i * 8), 64'h0000_0000_0000_E000 + 64'(i), 8'hCC), 1'b0, 1'b1);
      if (i == 0) base = cyc;
      expect_at(mk(32'h0002_3000 + 32'(i * 8), 64'h0000_0000_0000_D000 + 64'(i), 8'h0F), cyc + 1);
      if (i == 4) begin
        @(negedge clk);
        chk("full_no_drop_yet", 128'(strm_overflow), 128'(0));
      end
    end
    for (int i = 0; i < 4; i++)
      expect_at(mk(32'h0000_4000 + 32'(i * 8), 64'h0000_0000_0000_E000 + 64'(i), 8'hCC), base + 7 + i);
    @(negedge clk);
    chk("overflow_set", 128'(strm_overflow), 128'(1));
    // Full FIFO with a simultaneous dequeue accepts the new packet.
    step(idle_pkt, mk(32'h0002_5000, 64'h0000_0000_0000_F00D, 8'h81), 1'b0, 1'b1);
    expect_at(mk(32'h0002_5000, 64'h0000_0000_0000_F00D, 8'h81), base + 11);
    repeat (7) step(idle_pkt, idle_pkt, 1'b0, 1'b1);

    // Sticky flag clear, then clear coincident with a new drop.
    @(negedge clk);
    chk("overflow_sticky", 128'(strm_overflow), 128'(1));
    step(idle_pkt, idle_pkt, 1'b1, 1'b1);
    step(idle_pkt, idle_pkt, 1'b0, 1'b1);
    @(negedge clk);
    chk("overflow_cleared", 128'(strm_overflow), 128'(0));
    for (int i = 0; i < 6; i++) begin
      step(mk(32'h0000_6000 + 32'(i * 8), 64'h0000_0000_0000_6000 + 64'(i), 8'h11),
           mk(32'h0002_7000 + 32'(i * 8), 64'h0000_0000_0000_7000 + 64'(i), 8'h22), (i == 5), 1'b1);
      if (i == 0) base = cyc;
      expect_at(mk(32'h0000_6000 + 32'(i * 8), 64'h0000_0000_0000_6000 + 64'(i), 8'h11), cyc + 1);
    end
    expect_at(mk(32'h0002_7000, 64'h0000_0000_0000_7000, 8'h22), base + 7);
    @(negedge clk);
    chk("overflow_set_again", 128'(strm_overflow), 128'(1));
    step(idle_pkt, idle_pkt, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_vs_drop", 128'(strm_overflow), 128'(1));
    step(idle_pkt, idle_pkt, 1'b0, 1'b1);

    // Reset with three packets still queued: flushed, nothing issued afterwards.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int b = 0; b < BANKS_PER_TILE; b++) chk("midreset_bank", 128'(bank_wr_packet[b]), 128'(0));
    chk("midreset_pending", 128'(strm_wr_pending), 128'(0));
    chk("midreset_overflow", 128'(strm_overflow), 128'(0));
`ifdef GLB_WR_MUX_STATS_EN
    chk("midreset_wr_count", 128'(strm_wr_count), 128'(0));
    chk("midreset_stall_count", 128'(strm_stall_count), 128'(0));
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) step(idle_pkt, idle_pkt, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_reset_pending", 128'(strm_wr_pending), 128'(0));
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
